// File: rtl/lzc.sv
// lzc: leading/trailing zero counter with an all-zero flag.
// MODE = 0 counts trailing zeros (index of the lowest set bit); MODE = 1 counts leading zeros.
`default_nettype none

module lzc #(
   parameter int WIDTH = 8,
   parameter bit MODE  = 1'b0,
   parameter int CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] data,
   output logic [CntW-1:0]  cnt,
   output logic             empty
);

   always_comb begin
      cnt = '0;
      if (MODE == 1'b0) begin
         // Scan downwards so the lowest set bit is the last to win.
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data[i]) cnt = CntW'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) cnt = CntW'(WIDTH - 1 - i);
         end
      end
   end

   assign empty = ~|data;

endmodule

`default_nettype wire

// File: rtl/id_allocator.sv
// id_allocator: hands out unique IDs from a free bitmap (lowest index first)
// through a staged valid/ready port, and takes released IDs back into the pool.
`default_nettype none

module id_allocator #(
   parameter int NUM_IDS  = 8,
   parameter int IdWidth  = $clog2(NUM_IDS),
   parameter int CntWidth = $clog2(NUM_IDS + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   output logic                alloc_valid_o,
   input  logic                alloc_ready_i,
   output logic [IdWidth-1:0]  alloc_id_o,
   input  logic                release_valid_i,
   input  logic [IdWidth-1:0]  release_id_i,
   output logic                release_err_o,
   output logic [CntWidth-1:0] in_use_o,
   output logic                full_o
);

   localparam int                IdSpan     = 2 ** IdWidth;
   localparam logic [IdWidth:0]  NumIdsExt  = (IdWidth + 1)'(NUM_IDS);
   localparam logic [CntWidth-1:0] NumIdsCnt = CntWidth'(NUM_IDS);

   logic [NUM_IDS-1:0]  free_q;
   logic [NUM_IDS-1:0]  free_d;
   logic                stage_valid_q;
   logic [IdWidth-1:0]  stage_id_q;
   logic [CntWidth-1:0] in_use_q;
   logic [CntWidth-1:0] in_use_d;

   logic [IdWidth-1:0]  candidate;
   logic                none_free;
   logic                any_free;
   logic                hs;
   logic                load;
   logic [IdSpan-1:0]   free_pad;
   logic                rel_in_range;
   logic                rel_staged;
   logic                rel_legal;

   lzc #(
      .WIDTH (NUM_IDS),
      .MODE  (1'b0)
   ) u_lzc (
      .data  (free_q),
      .cnt   (candidate),
      .empty (none_free)
   );

   assign any_free = ~none_free;
   assign hs       = stage_valid_q & alloc_ready_i;
   assign load     = any_free & (~stage_valid_q | hs);

   // Padded copy so an out-of-range release ID never indexes past the bitmap.
   always_comb begin
      free_pad                = '0;
      free_pad[NUM_IDS-1:0]   = free_q;
   end

   assign rel_in_range  = {1'b0, release_id_i} < NumIdsExt;
   assign rel_staged    = stage_valid_q & (stage_id_q == release_id_i);
   assign rel_legal     = release_valid_i & rel_in_range & ~free_pad[release_id_i] & ~rel_staged;
   assign release_err_o = release_valid_i & ~rel_legal;

   // Load uses the old bitmap; the released bit can never be the candidate.
   always_comb begin
      free_d = free_q;
      if (load)      free_d[candidate]    = 1'b0;
      if (rel_legal) free_d[release_id_i] = 1'b1;
   end

   always_comb begin
      in_use_d = in_use_q;
      case ({hs, rel_legal})
         2'b10:   in_use_d = in_use_q + CntWidth'(1);
         2'b01:   in_use_d = in_use_q - CntWidth'(1);
         default: in_use_d = in_use_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         free_q        <= '1;
         stage_valid_q <= 1'b0;
         stage_id_q    <= '0;
         in_use_q      <= '0;
      end else if (flush_i) begin
         free_q        <= '1;
         stage_valid_q <= 1'b0;
         stage_id_q    <= '0;
         in_use_q      <= '0;
      end else begin
         free_q   <= free_d;
         in_use_q <= in_use_d;
         if (load) begin
            stage_valid_q <= 1'b1;
            stage_id_q    <= candidate;
         end else if (hs) begin
            stage_valid_q <= 1'b0;
         end
      end
   end

   assign alloc_valid_o = stage_valid_q;
   assign alloc_id_o    = stage_id_q;
   assign in_use_o      = in_use_q;
   assign full_o        = (in_use_q == NumIdsCnt);

`ifndef SYNTHESIS
   a_stage_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (alloc_valid_o && !alloc_ready_i && !flush_i) |=> (alloc_valid_o && $stable(alloc_id_o)));

   // Every ID is exactly one of: free, staged, or held by the consumer.
   a_conservation: assert property (@(posedge clk_i) disable iff (rst_i)
      (int'(in_use_q) + $countones(free_q) + int'(stage_valid_q)) == NUM_IDS);
`endif

endmodule

`default_nettype wire
